// File: rtl/spi_slave_duplex_if.sv
// Core-side streams of spi_slave_duplex: RX/TX valid-ready handshakes and event pulses.
interface spi_slave_duplex_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  overrun;
    logic                  underrun;
    logic                  frame_abort;

    modport slave (
        output rx_data, rx_valid, tx_ready, overrun, underrun, frame_abort,
        input  rx_ready, tx_data, tx_valid
    );

    modport master (
        input  rx_data, rx_valid, tx_ready, overrun, underrun, frame_abort,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/spi_slave_duplex.sv
// Full-duplex SPI slave, oversampled in the clk domain, with valid/ready RX and TX
// streams and overrun/underrun/abort event pulses.
module spi_slave_duplex #(
    parameter int DATA_WIDTH  = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic mosi,
    input  logic cs_n,
    output logic miso,
    output logic miso_oe,
    spi_slave_duplex_if.slave bus
);
    localparam int              CW       = $clog2(DATA_WIDTH);
    localparam logic            IDLE_LVL = (CPOL != 0);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic                   sclk_s, mosi_s, cs_n_s, sclk_prev;
    state_t                 state_q, state_d;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_WIDTH-1:0]  rx_shift, rx_word;
    logic [DATA_WIDTH-1:0]  tx_shift, tx_shift_d, tx_hold;
    logic                   hold_empty;
    logic                   lead_edge, trail_edge, sample_edge, shift_edge;
    logic                   frame_start, frame_end, in_frame;
    logic                   do_sample, word_done, do_load, do_shift, tx_head_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_prev <= IDLE_LVL;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_n_s = cs_sync[SYNC_STAGES-1];

    assign lead_edge   = (sclk_prev == IDLE_LVL) && (sclk_s != IDLE_LVL);
    assign trail_edge  = (sclk_prev != IDLE_LVL) && (sclk_s == IDLE_LVL);
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge  : trail_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!cs_n_s) state_d = ST_ACTIVE;
            ST_ACTIVE: if (cs_n_s)  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign frame_start = (state_q == ST_IDLE)   && !cs_n_s;
    assign frame_end   = (state_q == ST_ACTIVE) &&  cs_n_s;
    assign in_frame    = (state_q == ST_ACTIVE) && !cs_n_s;
    assign do_sample   = in_frame && sample_edge;
    assign word_done   = do_sample && (bit_cnt == LAST_BIT);
    assign do_load     = frame_start || word_done;
    // No shift at bit_cnt 0 so a freshly loaded head bit survives the first shift edge.
    assign do_shift    = in_frame && shift_edge && (bit_cnt != '0);

    assign rx_word = (MSB_FIRST != 0) ? {rx_shift[DATA_WIDTH-2:0], mosi_s}
                                      : {mosi_s, rx_shift[DATA_WIDTH-1:1]};

    always_comb begin
        tx_shift_d = tx_shift;
        if (frame_end)
            tx_shift_d = '0;
        else if (do_load)
            tx_shift_d = hold_empty ? '0 : tx_hold;
        else if (do_shift)
            tx_shift_d = (MSB_FIRST != 0) ? {tx_shift[DATA_WIDTH-2:0], 1'b0}
                                          : {1'b0, tx_shift[DATA_WIDTH-1:1]};
        tx_head_d = (MSB_FIRST != 0) ? tx_shift_d[DATA_WIDTH-1] : tx_shift_d[0];
    end

    assign bus.tx_ready = hold_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt         <= '0;
            rx_shift        <= '0;
            tx_shift        <= '0;
            tx_hold         <= '0;
            hold_empty      <= 1'b1;
            miso            <= 1'b0;
            miso_oe         <= 1'b0;
            bus.rx_data     <= '0;
            bus.rx_valid    <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.underrun    <= 1'b0;
            bus.frame_abort <= 1'b0;
        end else begin
            tx_shift        <= tx_shift_d;
            miso_oe         <= !cs_n_s;
            miso            <= !cs_n_s && tx_head_d;
            bus.underrun    <= do_load && hold_empty;
            bus.frame_abort <= frame_end && (bit_cnt != '0);
            bus.overrun     <= word_done && bus.rx_valid && !bus.rx_ready;

            // A load from an empty register sees empty even if a write lands this cycle.
            if (do_load && !hold_empty) begin
                hold_empty <= 1'b1;
            end else if (bus.tx_valid && hold_empty) begin
                hold_empty <= 1'b0;
                tx_hold    <= bus.tx_data;
            end

            if (frame_end) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (do_sample) begin
                bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
                rx_shift <= rx_word;
            end

            if (word_done && (!bus.rx_valid || bus.rx_ready)) begin
                bus.rx_data  <= rx_word;
                bus.rx_valid <= 1'b1;
            end else if (bus.rx_valid && bus.rx_ready) begin
                bus.rx_valid <= 1'b0;
            end
        end
    end
endmodule
